// File: rtl/color_scan_sequencer_pkg.sv
// Shared definitions for the colour scan sequencer: colour codes, FSM states
// and default parameter values.
package color_scan_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    BLUE   = 2'b10,
    YELLOW = 2'b11
  } color_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    TRIGGER,
    WAIT_RESULT,
    EVALUATE,
    NEXT_SLOT,
    DONE,
    ERROR
  } state_t;

  localparam int DEF_NUM_SLOTS      = 8;
  localparam int DEF_MATCH_COUNT    = 2;
  localparam int DEF_MAX_READS      = 8;
  localparam int DEF_SETTLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;

endpackage

// File: rtl/color_scan_sequencer_scan_timer.sv
// Loadable down-counter with terminal-count flag, shared by the settle wait and
// the detector timeout (the two never overlap).
module scan_timer #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/color_scan_sequencer.sv
// Sequences the colour detector across NUM_SLOTS slots and assembles the RGBY
// sequence. Define COLOR_SCAN_RETRY_EN to allow one re-settle retry per slot on timeout.
module color_scan_sequencer
  import color_scan_pkg::*;
#(
  parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
  parameter int MATCH_COUNT    = DEF_MATCH_COUNT,
  parameter int MAX_READS      = DEF_MAX_READS,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         scanStart,
  input  logic                         detectionComplete,
  input  logic [1:0]                   color,
  output logic                         startDetection,
  output logic [$clog2(NUM_SLOTS)-1:0] slotSelect,
  output logic                         scanBusy,
  output logic                         scanDone,
  output logic                         scanError,
  output logic [$clog2(NUM_SLOTS)-1:0] errorSlot,
  output logic [2*NUM_SLOTS-1:0]       colorSequence
);

  localparam int SW   = $clog2(NUM_SLOTS);
  localparam int RW   = $clog2(MAX_READS + 1);
  localparam int TMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  // Outputs are registered on state entry, so the timeout fires one cycle early
  // to put the scanError pulse exactly TIMEOUT_CYCLES after startDetection.
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [SW-1:0] LAST_SLOT    = SW'(NUM_SLOTS - 1);

  state_t          state;
  logic [RW-1:0]   readCnt;
  logic [2:0]      matchCnt;
  logic [2:0]      nextMatch;
  color_t          lastColor;
  color_t          colorReg;
  logic            timerLoad;
  logic [TW-1:0]   timerValue;
  logic            timerTc;
`ifdef COLOR_SCAN_RETRY_EN
  logic            retried;
`endif

  assign nextMatch = (colorReg == lastColor) ? matchCnt + 3'd1 : 3'd1;

  always_comb begin
    timerLoad  = 1'b0;
    timerValue = SETTLE_LOAD;
    case (state)
      IDLE:      timerLoad = scanStart;
      NEXT_SLOT: timerLoad = 1'b1;
      TRIGGER: begin
        timerLoad  = 1'b1;
        timerValue = TIMEOUT_LOAD;
      end
`ifdef COLOR_SCAN_RETRY_EN
      WAIT_RESULT: timerLoad = timerTc && !detectionComplete && !retried;
`endif
      default: ;
    endcase
  end

  scan_timer #(.WIDTH(TW)) timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timerLoad),
    .loadValue (timerValue),
    .tc        (timerTc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      startDetection <= 1'b0;
      slotSelect     <= '0;
      scanBusy       <= 1'b0;
      scanDone       <= 1'b0;
      scanError      <= 1'b0;
      errorSlot      <= '0;
      colorSequence  <= '0;
      readCnt        <= '0;
      matchCnt       <= '0;
      lastColor      <= RED;
      colorReg       <= RED;
`ifdef COLOR_SCAN_RETRY_EN
      retried        <= 1'b0;
`endif
    end else begin
      startDetection <= 1'b0;
      scanDone       <= 1'b0;
      scanError      <= 1'b0;
      case (state)
        IDLE: begin
          if (scanStart) begin
            colorSequence <= '0;
            errorSlot     <= '0;
            slotSelect    <= '0;
            readCnt       <= '0;
            matchCnt      <= '0;
`ifdef COLOR_SCAN_RETRY_EN
            retried       <= 1'b0;
`endif
            scanBusy      <= 1'b1;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (timerTc) begin
            startDetection <= 1'b1;
            state          <= TRIGGER;
          end
        end
        TRIGGER: state <= WAIT_RESULT;
        WAIT_RESULT: begin
          if (detectionComplete) begin
            colorReg <= color_t'(color);
            readCnt  <= readCnt + RW'(1);
            state    <= EVALUATE;
          end else if (timerTc) begin
`ifdef COLOR_SCAN_RETRY_EN
            if (!retried) begin
              retried <= 1'b1;
              state   <= SETTLE;
            end else begin
              scanError <= 1'b1;
              scanBusy  <= 1'b0;
              errorSlot <= slotSelect;
              state     <= ERROR;
            end
`else
            scanError <= 1'b1;
            scanBusy  <= 1'b0;
            errorSlot <= slotSelect;
            state     <= ERROR;
`endif
          end
        end
        EVALUATE: begin
          matchCnt  <= nextMatch;
          lastColor <= colorReg;
          if (nextMatch == 3'(MATCH_COUNT)) begin
            colorSequence[2*slotSelect +: 2] <= colorReg;
            state <= NEXT_SLOT;
          end else if (readCnt == RW'(MAX_READS)) begin
            scanError <= 1'b1;
            scanBusy  <= 1'b0;
            errorSlot <= slotSelect;
            state     <= ERROR;
          end else begin
            startDetection <= 1'b1;
            state          <= TRIGGER;
          end
        end
        NEXT_SLOT: begin
          readCnt  <= '0;
          matchCnt <= '0;
`ifdef COLOR_SCAN_RETRY_EN
          retried  <= 1'b0;
`endif
          if (slotSelect == LAST_SLOT) begin
            scanDone <= 1'b1;
            scanBusy <= 1'b0;
            state    <= DONE;
          end else begin
            slotSelect <= slotSelect + SW'(1);
            state      <= SETTLE;
          end
        end
        DONE:    state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Self-checking bench for color_scan_sequencer: directed and random scans scored
// against a read-list model of the agreement/timeout rules.
module tb_color_scan_sequencer;

  localparam int NS = 4;
  localparam int MC = 2;
  localparam int MR = 4;
  localparam int SC = 8;
  localparam int TC = 40;
  localparam int SILENT = 4;
`ifdef COLOR_SCAN_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       scanStart = 1'b0;
  logic       detectionComplete = 1'b0;
  logic [1:0] color = 2'b00;
  logic       startDetection, scanBusy, scanDone, scanError;
  logic [1:0] slotSelect, errorSlot;
  logic [7:0] colorSequence;

  int nCmp = 0;
  int nBad = 0;
  int cyc = 0;
  int rd [NS][8];
  int idx [NS];
  int trig [NS];
  int lastTrigCyc = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int errCyc = 0;

  int         expTrig [NS];
  bit         expErr, expTimeout;
  int         expSlot;
  logic [7:0] expSeq;

  color_scan_sequencer #(
    .NUM_SLOTS      (NS),
    .MATCH_COUNT    (MC),
    .MAX_READS      (MR),
    .SETTLE_CYCLES  (SC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .scanStart         (scanStart),
    .detectionComplete (detectionComplete),
    .color             (color),
    .startDetection    (startDetection),
    .slotSelect        (slotSelect),
    .scanBusy          (scanBusy),
    .scanDone          (scanDone),
    .scanError         (scanError),
    .errorSlot         (errorSlot),
    .colorSequence     (colorSequence)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse monitor.
  always begin
    @(negedge clk);
    if (scanDone) doneCnt++;
    if (scanError) begin
      errCnt++;
      errCyc = cyc;
    end
  end

  // Detector model: answers each request from the per-slot read list after 1..4 cycles.
  always begin
    int s, v, lat;
    @(negedge clk);
    if (startDetection) begin
      s = int'(slotSelect);
      trig[s]++;
      lastTrigCyc = cyc;
      v = (idx[s] < 8) ? rd[s][idx[s]] : SILENT;
      idx[s]++;
      if (v != SILENT) begin
        lat = $urandom_range(1, 4);
        repeat (lat) @(negedge clk);
        color = 2'(v);
        detectionComplete = 1'b1;
        @(negedge clk);
        detectionComplete = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks each slot's read list: a run of MC equal colours commits, MR reads
  // without agreement or an unanswered request (after the optional retry) aborts.
  task automatic model();
    int prev, run, n;
    bit retried, committed;
    expSeq = '0;
    expErr = 1'b0;
    expTimeout = 1'b0;
    expSlot = 0;
    for (int s = 0; s < NS; s++) expTrig[s] = 0;
    for (int s = 0; s < NS && !expErr; s++) begin
      prev = -1; run = 0; n = 0; retried = 1'b0; committed = 1'b0;
      for (int k = 0; k < 8 && !committed && !expErr; k++) begin
        expTrig[s]++;
        if (rd[s][k] == SILENT) begin
          if (RETRY && !retried) retried = 1'b1;
          else begin
            expErr = 1'b1;
            expTimeout = 1'b1;
            expSlot = s;
          end
        end else begin
          n++;
          run = (rd[s][k] == prev) ? run + 1 : 1;
          prev = rd[s][k];
          if (run == MC) begin
            expSeq[2*s +: 2] = 2'(rd[s][k]);
            committed = 1'b1;
          end else if (n == MR) begin
            expErr = 1'b1;
            expSlot = s;
          end
        end
      end
    end
  endtask

  task automatic fillAgree();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 8; k++) rd[s][k] = s;
  endtask

  task automatic runScan(input string name, input bit poke);
    int waited;
    for (int s = 0; s < NS; s++) begin
      idx[s] = 0;
      trig[s] = 0;
    end
    doneCnt = 0;
    errCnt = 0;
    model();
    @(negedge clk);
    scanStart = 1'b1;
    @(negedge clk);
    scanStart = 1'b0;
    waited = 0;
    while (doneCnt + errCnt == 0 && waited < 4000) begin
      @(negedge clk);
      waited++;
      scanStart = (poke && waited == 30);
    end
    scanStart = 1'b0;
    chk({name, ".ended"}, doneCnt + errCnt, 1);
    repeat (3) @(negedge clk);
    chk({name, ".done"}, doneCnt, expErr ? 0 : 1);
    chk({name, ".error"}, errCnt, expErr ? 1 : 0);
    chk({name, ".seq"}, colorSequence, expSeq);
    chk({name, ".busy"}, scanBusy, 0);
    for (int s = 0; s < NS; s++) chk($sformatf("%s.trig%0d", name, s), trig[s], expTrig[s]);
    if (expErr) chk({name, ".errSlot"}, errorSlot, expSlot);
    if (expTimeout) chk({name, ".toLatency"}, errCyc - lastTrigCyc, TC);
  endtask

  initial begin
    int t, waited;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst.start", startDetection, 0);
    chk("rst.busy", scanBusy, 0);
    chk("rst.done", scanDone, 0);
    chk("rst.error", scanError, 0);
    chk("rst.slot", slotSelect, 0);
    chk("rst.errSlot", errorSlot, 0);
    chk("rst.seq", colorSequence, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    fillAgree();
    runScan("agree", 1'b0);
    chk("agree.seqConst", colorSequence, 8'hE4);
    chk("agree.trigTotal", trig[0] + trig[1] + trig[2] + trig[3], 8);

    fillAgree();
    rd[0][0] = 0; rd[0][1] = 1; rd[0][2] = 1;
    runScan("recover", 1'b0);
    chk("recover.slot0", colorSequence[1:0], 2'b01);

    fillAgree();
    rd[2][0] = 0; rd[2][1] = 1; rd[2][2] = 0; rd[2][3] = 1;
    runScan("noAgree", 1'b0);

    fillAgree();
    for (int k = 0; k < 8; k++) rd[1][k] = SILENT;
    runScan("timeout", 1'b0);

    fillAgree();
    rd[3][0] = 2; rd[3][1] = 1; rd[3][2] = 1;
    runScan("busyPoke", 1'b1);
    repeat (3) @(negedge clk);
    chk("busyPoke.noRestart", scanBusy, 0);

    for (int i = 0; i < 25; i++) begin
      for (int s = 0; s < NS; s++) begin
        t = $urandom_range(0, 3);
        for (int k = 0; k < 8; k++)
          rd[s][k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : t;
      end
      if ($urandom_range(0, 4) == 0) rd[$urandom_range(0, 3)][$urandom_range(0, 2)] = SILENT;
      runScan($sformatf("rand%0d", i), 1'b0);
    end

    // Reset asserted while the DUT waits on an unanswered request.
    fillAgree();
    rd[0][0] = SILENT;
    for (int s = 0; s < NS; s++) begin
      idx[s] = 0;
      trig[s] = 0;
    end
    doneCnt = 0;
    errCnt = 0;
    @(negedge clk);
    scanStart = 1'b1;
    @(negedge clk);
    scanStart = 1'b0;
    waited = 0;
    while (trig[0] == 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("midRst.triggered", trig[0], 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midRst.start", startDetection, 0);
    chk("midRst.busy", scanBusy, 0);
    chk("midRst.done", scanDone, 0);
    chk("midRst.error", scanError, 0);
    chk("midRst.slot", slotSelect, 0);
    chk("midRst.errSlot", errorSlot, 0);
    chk("midRst.seq", colorSequence, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("midRst.noDone", doneCnt, 0);
    chk("midRst.noError", errCnt, 0);
    chk("midRst.idle", scanBusy, 0);
    chk("midRst.noTrig", trig[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
